// File: rtl/encoder_layer_0_intermediate_dense_weight_sink_pkg.sv
// ----------------------------------------------------------------------------
// encoder_layer_0_intermediate_dense_weight_sink_pkg
//
// Purpose: shared types and helpers for the intermediate dense weight
// sink. The source side uses the same lane_offset() for unpacking, so
// both directions agree on where each lane lives inside a RAM line.
//
// Contents:
//   sink_state_e  - load FSM states (IDLE, FILL, WRITE, DONE)
//   lane_offset() - bit offset of (beat, lane) inside a packed line
// ----------------------------------------------------------------------------
package encoder_layer_0_intermediate_dense_weight_sink_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } sink_state_e;

    // Element (beat * lanes + lane) of a line occupies bits
    // [offset +: prec]. Lane 0 of beat 0 is the least significant element.
    function automatic int unsigned lane_offset(
        input int unsigned beat,
        input int unsigned lane,
        input int unsigned lanes,
        input int unsigned prec
    );
        return prec * (beat * lanes + lane);
    endfunction

endpackage

// File: rtl/encoder_layer_0_intermediate_dense_weight_sink_if.sv
// ----------------------------------------------------------------------------
// encoder_layer_0_intermediate_dense_weight_sink_if
//
// Purpose: valid/ready weight beat stream feeding the weight sink.
//
// Signals:
//   data_in        [LANES][PREC] beat lanes, lane j = data_in[j]
//   data_in_valid  beat valid (driven by master)
//   data_in_ready  sink can accept a beat (driven by slave)
//
// Modports: master = upstream producer, slave = weight sink.
// ----------------------------------------------------------------------------
interface encoder_layer_0_intermediate_dense_weight_sink_if #(
    parameter int LANES = 4,
    parameter int PREC  = 16
);
    logic [LANES-1:0][PREC-1:0] data_in;
    logic                       data_in_valid;
    logic                       data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/encoder_layer_0_intermediate_dense_weight_sink_weight_line_packer.sv
// ----------------------------------------------------------------------------
// encoder_layer_0_intermediate_dense_weight_sink_weight_line_packer
//
// Purpose: collects BEATS beats of LANES elements into one line.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   clear          restart at beat 0 (load armed)
//   accept         a beat is transferred this cycle
//   beat_lanes     lanes of the beat being transferred
//   line_complete  the accepted beat is the last beat of the line
//   line           line buffer contents including this cycle's beat
// ----------------------------------------------------------------------------
module encoder_layer_0_intermediate_dense_weight_sink_weight_line_packer
    import encoder_layer_0_intermediate_dense_weight_sink_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PREC  = 16,
    parameter int ELEMS = 32,
    parameter int BEATS = ELEMS / LANES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       accept,
    input  logic [LANES-1:0][PREC-1:0] beat_lanes,
    output logic                       line_complete,
    output logic [PREC*ELEMS-1:0]      line
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [PREC*ELEMS-1:0] line_q, line_d;

    assign line_complete = accept && (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign line          = line_d;

    // Each beat slot owns a fixed bit range, so the write mux per slot
    // uses constant offsets rather than a variable part-select.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        logic slot_hit;
        assign slot_hit = accept && (beat_cnt_q == BEAT_W'(gi));
        for (genvar gj = 0; gj < LANES; gj++) begin : g_lane
            localparam int unsigned OFS = lane_offset(gi, gj, LANES, PREC);
            assign line_d[OFS +: PREC] = slot_hit ? beat_lanes[gj]
                                                  : line_q[OFS +: PREC];
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clear) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = line_complete ? '0 : beat_cnt_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_q <= '0;
            line_q     <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            line_q     <= line_d;
        end
    end

endmodule

// File: rtl/encoder_layer_0_intermediate_dense_weight_sink.sv
// ----------------------------------------------------------------------------
// encoder_layer_0_intermediate_dense_weight_sink
//
// Purpose: accepts a stream of weight beats, packs them into full lines and
// writes one line per RAM address. Raises done after
// WEIGHT_TENSOR_SIZE_DIM_1 lines have been written.
//
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   start       single-cycle pulse, arms a load from IDLE or DONE
//   s_if        beat stream (slave): data_in, data_in_valid, data_in_ready
//   mem_we      RAM write enable (high for the single WRITE cycle)
//   mem_addr    RAM write address (holds its last value when idle)
//   mem_wdata   packed line (holds its last value when idle)
//   done        all lines written
//   busy        load in progress (FILL or WRITE)
// ----------------------------------------------------------------------------
module encoder_layer_0_intermediate_dense_weight_sink
    import encoder_layer_0_intermediate_dense_weight_sink_pkg::*;
#(
    parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
    parameter int WEIGHT_TENSOR_SIZE_DIM_1 = 4,
    parameter int WEIGHT_PRECISION_0       = 16,
    parameter int WEIGHT_PRECISION_1       = 3,
    parameter int WEIGHT_PARALLELISM_DIM_0 = 4,
    parameter int BEATS_PER_LINE = WEIGHT_TENSOR_SIZE_DIM_0 / WEIGHT_PARALLELISM_DIM_0,
    parameter int ADDR_WIDTH     = $clog2(WEIGHT_TENSOR_SIZE_DIM_1) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    encoder_layer_0_intermediate_dense_weight_sink_if.slave s_if,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WEIGHT_PRECISION_0*WEIGHT_TENSOR_SIZE_DIM_0-1:0] mem_wdata,
    output logic                  done,
    output logic                  busy
);

    localparam int LINE_BITS = WEIGHT_PRECISION_0 * WEIGHT_TENSOR_SIZE_DIM_0;

    // Elaboration-time parameter sanity checks; they generate no logic.
    if (WEIGHT_TENSOR_SIZE_DIM_0 % WEIGHT_PARALLELISM_DIM_0 != 0) begin : g_bad_parallelism
        $error("WEIGHT_PARALLELISM_DIM_0 must divide WEIGHT_TENSOR_SIZE_DIM_0");
    end
    if (WEIGHT_PRECISION_1 > WEIGHT_PRECISION_0) begin : g_bad_fraction
        $error("WEIGHT_PRECISION_1 cannot exceed WEIGHT_PRECISION_0");
    end

    sink_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0]  mem_wdata_q, mem_wdata_d;

    logic                  arm_load;
    logic                  beat_accept;
    logic                  line_complete;
    logic [LINE_BITS-1:0]  line_full;

    // Ready is decoded from state only, so valid never reaches ready
    // combinationally.
    assign beat_accept = s_if.data_in_valid && (state_q == FILL);

    encoder_layer_0_intermediate_dense_weight_sink_weight_line_packer #(
        .LANES (WEIGHT_PARALLELISM_DIM_0),
        .PREC  (WEIGHT_PRECISION_0),
        .ELEMS (WEIGHT_TENSOR_SIZE_DIM_0),
        .BEATS (BEATS_PER_LINE)
    ) u_packer (
        .clk           (clk),
        .rst           (rst),
        .clear         (arm_load),
        .accept        (beat_accept),
        .beat_lanes    (s_if.data_in),
        .line_complete (line_complete),
        .line          (line_full)
    );

    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        arm_load    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    arm_load   = 1'b1;
                    line_cnt_d = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                // Capture the finished line (including the beat taken this
                // cycle) so the write port presents it during WRITE.
                if (line_complete) begin
                    mem_addr_d  = line_cnt_q;
                    mem_wdata_d = line_full;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                if (line_cnt_q == ADDR_WIDTH'(WEIGHT_TENSOR_SIZE_DIM_1 - 1)) begin
                    state_d = DONE;
                end else begin
                    line_cnt_d = line_cnt_q + ADDR_WIDTH'(1);
                    state_d    = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            line_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign s_if.data_in_ready = (state_q == FILL);
    assign mem_we             = (state_q == WRITE);
    assign done               = (state_q == DONE);
    assign busy               = (state_q == FILL) || (state_q == WRITE);
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;

endmodule

// File: doc/encoder_layer_0_intermediate_dense_weight_sink.md
Name: encoder_layer_0_intermediate_dense_weight_sink

Overview:
- Write-side counterpart of the intermediate dense weight source.
- Accepts a valid/ready stream of weight beats, each beat WEIGHT_PARALLELISM_DIM_0 lanes wide.
- Packs consecutive beats into one full line of WEIGHT_TENSOR_SIZE_DIM_0 elements and writes each completed line to a single-port weight RAM, one line per address.
- Used to load or refresh weight memory at runtime; raises done after WEIGHT_TENSOR_SIZE_DIM_1 lines have been written.

Parameters:
- WEIGHT_TENSOR_SIZE_DIM_0, 32: elements per line (per RAM word).
- WEIGHT_TENSOR_SIZE_DIM_1, 4: lines to load, equal to the RAM depth.
- WEIGHT_PRECISION_0, 16: element width in bits.
- WEIGHT_PRECISION_1, 3: fractional bits; informational only, no arithmetic.
- WEIGHT_PARALLELISM_DIM_0, 4: lanes per input beat; must divide WEIGHT_TENSOR_SIZE_DIM_0.
- BEATS_PER_LINE, WEIGHT_TENSOR_SIZE_DIM_0/WEIGHT_PARALLELISM_DIM_0: derived.
- ADDR_WIDTH, $clog2(WEIGHT_TENSOR_SIZE_DIM_1)+1: RAM address width, matching the source convention.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; arms a load from IDLE or DONE.
- data_in  in  [WEIGHT_PRECISION_0-1:0] x [WEIGHT_PARALLELISM_DIM_0]  beat lanes.
- data_in_valid  in  1  beat valid.
- data_in_ready  out  1  sink can accept a beat.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM write address.
- mem_wdata  out  WEIGHT_PRECISION_0*WEIGHT_TENSOR_SIZE_DIM_0  packed line.
- done  out  1  all lines written.
- busy  out  1  high in FILL or WRITE.

Behaviour:
- Reset (rst=0, takes effect asynchronously): state=IDLE; beat_cnt=0; line_cnt=0; line buffer=0; data_in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, busy=0.
- All outputs are registered or decoded purely from state. No combinational path from data_in_valid to data_in_ready.
- Transfer rule: a beat is accepted on a rising edge where data_in_valid && data_in_ready.
- State IDLE: ready=0. On start, clear beat_cnt and line_cnt, then go to FILL.
- State FILL: ready=1.
  - On each accepted beat b=beat_cnt, lane j is stored at line bits [P*(b*WEIGHT_PARALLELISM_DIM_0+j) +: P], where P=WEIGHT_PRECISION_0. This is the same lane/bit order the source uses when unpacking.
  - Then beat_cnt increments.
  - If the accepted beat is beat BEATS_PER_LINE-1: beat_cnt wraps to 0, the registered mem_wdata takes the completed line (including this beat), mem_addr=line_cnt, mem_we=1 on the next cycle, and the state goes to WRITE.
- State WRITE (exactly 1 cycle): mem_we=1, ready=0.
  - If line_cnt==WEIGHT_TENSOR_SIZE_DIM_1-1, go to DONE.
  - Otherwise line_cnt increments and the state returns to FILL.
- State DONE: done=1, ready=0, mem_we=0. On start, re-arm: clear counters, go to FILL, done drops the next cycle.
- Latency: the last beat of a line is accepted at edge N; mem_we is high for cycle N+1 only; ready returns at N+2.
- Throughput: BEATS_PER_LINE+1 cycles per line with valid held high.
- start is ignored in FILL and WRITE.
- data_in_valid while ready=0 is held off; the upstream must keep data stable.
- Reset mid-load aborts immediately. No partial line is written, and the RAM keeps whatever was already written.
- The line buffer is not cleared between lines; every bit is overwritten before each write.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, FILL, WRITE, DONE};
  - the lane-offset helper function (beat, lane -> bit offset), reused by the source for unpacking.
- One natural sub-module, weight_line_packer: beat_cnt plus the line buffer, with outputs line_complete and line.
- The FSM, line counter and RAM write port stay in the top.

Test Plan:
- Default parameters. Reset, pulse start, stream 32 beats with lane value = global element index (0..127), valid always high.
  - Required: 4 mem_we pulses at addr 0,1,2,3, spaced 9 cycles apart.
  - Required: word k element e equals 32k+e.
  - Required: done=1 after the 4th write.
- Random valid gaps (~50% duty) with the same data.
  - Required: identical RAM contents.
  - Required: no beat lost or duplicated.
  - Required: ready=0 exactly during WRITE.
- Single line: last beat of line 0 accepted at edge N.
  - Required: mem_we=1 only in cycle N+1, mem_addr=0, ready=0 in that cycle and ready=1 at N+2.
- start pulsed during FILL.
  - Required: no effect; line_cnt and beat_cnt continue.
  - Required: after DONE, a second start with data 0xFFFF on all lanes rewrites all 4 words to all-ones.
- rst driven low after 20 beats.
  - Required: outputs go to reset values asynchronously, before the next clock edge.
  - Required: only addresses 0 and 1 were written.
  - Required: ready=0 until the next start.
- Parameter set WEIGHT_PARALLELISM_DIM_0=32 (BEATS_PER_LINE=1).
  - Required: one write every 2 cycles.
  - Required: element order matches the source unpacking.
